audio_clip_scheduler: RTL and testbench
=======================================

Name: audio_clip_scheduler

Overview:
- Sample-rate sequencer for WM8731 playback.
- Owns the audio ROM read side: arbitrates between NUM_CLIPS clip requesters (e.g. station announcements, chime) and generates one ROM address per DAC_LR_CLK period for the granted clip.
- Inserts a silence gap between clips.
- Sits between the request sources and the audio ROM / DAC serializer, after codec I2C configuration has completed.

Parameters:
- NUM_CLIPS, 4, number of requesters/clips.
- ADDR_W, 18, ROM address width.
- GAP_SAMPLES, 4800, silence samples between clips (0.1 s at 48 kHz); 0 = no gap.
- GAP_W, 13, gap counter width; must hold GAP_SAMPLES.

Ports:
- DAC_LR_CLK  in  1  sample clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- enable  in  1  codec configured; playback allowed.
- req  in  NUM_CLIPS  per-clip request, level or pulse, sampled each cycle.
- abort  in  1  stop the current clip.
- rom_addr  out  ADDR_W  ROM read address.
- rom_rden  out  1  ROM read enable.
- mute  out  1  serializer must output zero data.
- busy  out  1  state is START, PLAY or GAP.
- grant  out  NUM_CLIPS  one-hot; the clip currently playing.
- clip_done  out  1  one-cycle pulse when a clip completes normally.

Behaviour:
- Reset (reset=0 at edge):
  - State IDLE; pending=0.
  - rom_addr=0, rom_rden=0, mute=1, busy=0, grant=0, clip_done=0.
  - Applies mid-clip; no clip_done is issued.
- Pending register:
  - pending <= (pending & ~clear) | req.
  - clear is the one-hot grant issued this cycle.
  - Set wins, so a request coincident with its own grant queues one replay.
  - Multiple pulses before a grant collapse to one play.
- Arbitration: fixed priority, lowest index wins (see Optional Feature).
- States:
  - IDLE: if enable and pending!=0 → START; latch grant; rom_addr=CLIP_START[g]; rom_rden=1; offset=0; mute stays 1.
  - START: one cycle covering ROM read latency. rom_addr+1, offset+1. → PLAY; mute=0 next cycle.
  - PLAY: each cycle rom_addr+1 and offset+1.
    - When offset==CLIP_LEN[g]-1 (last address issued): next cycle → GAP; clip_done=1 for 1 cycle; rom_rden=0; mute=1; grant=0.
    - CLIP_LEN=1: START is the last address, so clip_done fires on the START→GAP transition.
  - GAP: counts GAP_SAMPLES cycles with mute=1, then → IDLE. If GAP_SAMPLES=0, PLAY goes directly to IDLE.
- abort=1 in START/PLAY: next cycle → GAP; rom_rden=0, mute=1, grant=0, no clip_done. abort is ignored in IDLE/GAP.
- enable=0 in any state: next cycle → IDLE; rom_rden=0, mute=1, grant=0; pending retained; no clip_done.
- Width rules:
  - rom_addr = CLIP_START + offset, computed in ADDR_W, with no wrap.
  - Package guarantees CLIP_START+CLIP_LEN <= 2^ADDR_W and CLIP_LEN>=1.
  - Offset counter is ADDR_W wide.
- busy=1 exactly in START, PLAY and GAP.

Optional Feature:
- Macro: AUDIO_SCHED_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A pointer register (reset 0) is set to (granted index+1) mod NUM_CLIPS on each grant; search starts at the pointer.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Package audio_sched_pkg holds:
  - NUM_CLIPS, ADDR_W.
  - CLIP_START / CLIP_LEN constant arrays. Default: starts 0, 50000, 100000, 150000; lengths 50000 each.
  - State enum: IDLE, START, PLAY, GAP.
- One sub-module, clip_arbiter:
  - Input: pending.
  - Outputs: one-hot grant, index, valid.
  - Contains the round-robin pointer when the macro is defined.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with enable=1, req=0 → rom_rden=0, mute=1, busy=0, grant=0 indefinitely.
- Single clip: req=4'b0010 pulse → grant=0010; rom_addr sequence 50000..99999 on consecutive cycles; mute=0 from second rden cycle; clip_done at cycle after 99999; then GAP_SAMPLES (bench override 4) muted cycles; busy=0.
- Contention: req=4'b1010 same cycle → clip 1 plays first, then gap, then clip 3 (150000..). With AUDIO_SCHED_ROUND_ROBIN_EN, req 0001 repeated each clip alongside 0010 → grants alternate 0001/0010.
- Abort: abort=1 when rom_addr=50010 → next cycle rom_rden=0, mute=1, grant=0, no clip_done; GAP then IDLE.
- Enable drop / reset mid-clip: enable=0 during PLAY of clip 2 with req 0001 pending → IDLE next cycle. Re-assert enable → clip 0 plays (pending kept). Reset during PLAY → all outputs at reset values, pending cleared.
- Requeue: req 0100 asserted on the same cycle clip 2 is granted → clip 2 plays twice with a gap between.

Source files
------------

// File: rtl/audio_clip_scheduler_pkg.sv
// Shared constants, clip table and state encoding for the audio clip scheduler.
package audio_sched_pkg;

  localparam int unsigned NUM_CLIPS = 4;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned IDX_W     = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;

  typedef logic [NUM_CLIPS-1:0][ADDR_W-1:0] clip_tbl_t;

  // Clip layout in the audio ROM; start+len never exceeds 2^ADDR_W and len >= 1.
  localparam clip_tbl_t CLIP_START = {ADDR_W'(150000), ADDR_W'(100000),
                                      ADDR_W'(50000),  ADDR_W'(0)};
  localparam clip_tbl_t CLIP_LEN   = {ADDR_W'(50000), ADDR_W'(50000),
                                      ADDR_W'(50000), ADDR_W'(50000)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/audio_clip_scheduler_if.sv
// Request/ROM/serializer signal bundle between clip sources and the scheduler.
interface audio_sched_if;
  import audio_sched_pkg::*;

  logic [NUM_CLIPS-1:0] req;
  logic                 abort;
  logic [ADDR_W-1:0]    rom_addr;
  logic                 rom_rden;
  logic                 mute;
  logic                 busy;
  logic [NUM_CLIPS-1:0] grant;
  logic                 clip_done;

  modport master (
    output req, abort,
    input  rom_addr, rom_rden, mute, busy, grant, clip_done
  );

  modport slave (
    input  req, abort,
    output rom_addr, rom_rden, mute, busy, grant, clip_done
  );

endinterface

// File: rtl/audio_clip_scheduler_clip_arbiter.sv
// Picks one pending clip: lowest index by default, round-robin from a rotating
// pointer when AUDIO_SCHED_ROUND_ROBIN_EN is defined.
module clip_arbiter
  import audio_sched_pkg::*;
(
`ifdef AUDIO_SCHED_ROUND_ROBIN_EN
  input  logic                 DAC_LR_CLK,
  input  logic                 reset,
  input  logic                 take,
`endif
  input  logic [NUM_CLIPS-1:0] pending,
  output logic [NUM_CLIPS-1:0] grant_c,
  output logic [IDX_W-1:0]     index_c,
  output logic                 valid_c
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;

`ifdef AUDIO_SCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  assign base = ptr_q;

  // Pointer moves just past the clip granted this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      if (index_c == IDX_W'(NUM_CLIPS - 1)) ptr_d = '0;
      else                                  ptr_d = index_c + IDX_W'(1);
    end
  end

  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign base = '0;
`endif

  // First pending clip found when scanning upward from base, wrapping.
  always_comb begin
    grant_c = '0;
    index_c = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CLIPS; i++) begin
      cand = IDX_W'((32'(base) + i) % NUM_CLIPS);
      if (!valid_c && pending[cand]) begin
        valid_c = 1'b1;
        index_c = cand;
      end
    end
    if (valid_c) grant_c[index_c] = 1'b1;
  end

endmodule

// File: rtl/audio_clip_scheduler.sv
// One ROM address per DAC_LR_CLK for the granted clip, with a muted gap between
// clips. Define AUDIO_SCHED_ROUND_ROBIN_EN for round-robin clip arbitration.
module audio_clip_scheduler
  import audio_sched_pkg::*;
#(
  parameter int unsigned GAP_SAMPLES    = 4800,
  parameter int unsigned GAP_W          = 13,
  parameter clip_tbl_t   CLIP_START_TBL = CLIP_START,
  parameter clip_tbl_t   CLIP_LEN_TBL   = CLIP_LEN
) (
  input  logic         DAC_LR_CLK,
  input  logic         reset,
  input  logic         enable,
  audio_sched_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

  sched_state_e         state_q,     state_d;
  logic [NUM_CLIPS-1:0] pending_q,   pending_d;
  logic [ADDR_W-1:0]    offset_q,    offset_d;
  logic [ADDR_W-1:0]    rom_addr_q,  rom_addr_d;
  logic                 rom_rden_q,  rom_rden_d;
  logic                 mute_q,      mute_d;
  logic                 busy_q,      busy_d;
  logic [NUM_CLIPS-1:0] grant_q,     grant_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic                 clip_done_q, clip_done_d;
  logic [GAP_W-1:0]     gap_cnt_q,   gap_cnt_d;

  logic [NUM_CLIPS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 arb_take;
  logic [NUM_CLIPS-1:0] pend_clear;
  logic                 last_c;
  logic                 stop;

  clip_arbiter u_arb (
`ifdef AUDIO_SCHED_ROUND_ROBIN_EN
    .DAC_LR_CLK (DAC_LR_CLK),
    .reset      (reset),
    .take       (arb_take),
`endif
    .pending    (pending_q),
    .grant_c    (arb_grant),
    .index_c    (arb_idx),
    .valid_c    (arb_valid)
  );

`ifdef AUDIO_SCHED_ROUND_ROBIN_EN
`else
  logic unused_take;
  assign unused_take = arb_take;
`endif

  // Offset of the address currently on rom_addr equals the clip's final sample.
  assign last_c = (offset_q == (CLIP_LEN_TBL[idx_q] - ADDR_W'(1)));

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    rom_addr_d  = rom_addr_q;
    rom_rden_d  = rom_rden_q;
    mute_d      = mute_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    clip_done_d = 1'b0;
    gap_cnt_d   = gap_cnt_q;
    pend_clear  = '0;
    arb_take    = 1'b0;
    stop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && arb_valid) begin
          state_d    = START;
          grant_d    = arb_grant;
          idx_d      = arb_idx;
          pend_clear = arb_grant;
          arb_take   = 1'b1;
          offset_d   = '0;
          rom_addr_d = CLIP_START_TBL[arb_idx];
          rom_rden_d = 1'b1;
          mute_d     = 1'b1;
        end
      end
      START, PLAY: begin
        if (bus.abort) begin
          stop = 1'b1;
        end else if (last_c) begin
          stop        = 1'b1;
          clip_done_d = 1'b1;
        end else begin
          state_d    = PLAY;
          offset_d   = offset_q + ADDR_W'(1);
          rom_addr_d = CLIP_START_TBL[idx_q] + offset_d;
          mute_d     = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Clip ends (normally or aborted): silence, then the gap if one is configured.
    if (stop) begin
      state_d    = (GAP_SAMPLES == 0) ? IDLE : GAP;
      gap_cnt_d  = GAP_LOAD;
      rom_rden_d = 1'b0;
      mute_d     = 1'b1;
      grant_d    = '0;
    end

    // Codec not ready: drop playback immediately but keep queued requests.
    if (!enable) begin
      state_d     = IDLE;
      rom_rden_d  = 1'b0;
      mute_d      = 1'b1;
      grant_d     = '0;
      clip_done_d = 1'b0;
    end

    pending_d = (pending_q & ~pend_clear) | bus.req;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      offset_q    <= '0;
      rom_addr_q  <= '0;
      rom_rden_q  <= 1'b0;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      idx_q       <= '0;
      clip_done_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      offset_q    <= offset_d;
      rom_addr_q  <= rom_addr_d;
      rom_rden_q  <= rom_rden_d;
      mute_q      <= mute_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      clip_done_q <= clip_done_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_rden  = rom_rden_q;
  assign bus.mute      = mute_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.clip_done = clip_done_q;

endmodule

// File: tb/tb_audio_clip_scheduler.sv
// Scoreboard bench for audio_clip_scheduler: a sample-level playback model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_audio_clip_scheduler;
  import audio_sched_pkg::*;

  localparam int GAP = 4;
  localparam int LEN     [4] = '{12, 20, 9, 1};
  localparam int START_A [4] = '{0, 50000, 100000, 150000};

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   errors = 0;
  int   checks = 0;

  audio_sched_if bus ();

  audio_clip_scheduler #(
    .GAP_SAMPLES  (GAP),
    .GAP_W        (13),
    .CLIP_LEN_TBL ({ADDR_W'(1), ADDR_W'(9), ADDR_W'(20), ADDR_W'(12)})
  ) dut (
    .DAC_LR_CLK (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rden;
    logic        mute;
    logic        busy;
    logic        done;
    logic [3:0]  grant;
    logic        chk_addr;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  // Playback model: which clip is sounding, which sample of it, how much gap remains.
  int         m_cur = -1;
  int         m_pos = 0;
  int         m_gap = 0;
  int         m_ptr = 0;
  logic [3:0] m_pend = '0;

  function automatic int pick(input logic [3:0] p, input int ptr);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   g;
    logic done;
    g    = -1;
    done = 1'b0;
    e    = '0;
    if (!reset) begin
      m_cur = -1; m_gap = 0; m_pend = '0; m_ptr = 0;
      e.mute = 1'b1; e.chk_addr = 1'b1; e.addr = 0;
    end else begin
      if (!enable) begin
        m_cur = -1; m_gap = 0;
      end else if (m_cur >= 0) begin
        if (bus.abort || m_pos == LEN[m_cur] - 1) begin
          done  = !bus.abort;
          m_cur = -1;
          m_gap = GAP;
        end else begin
          m_pos++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_pend != 4'b0) begin
        g     = pick(m_pend, m_ptr);
        m_cur = g;
        m_pos = 0;
`ifdef AUDIO_SCHED_ROUND_ROBIN_EN
        m_ptr = (g + 1) % 4;
`endif
      end
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | bus.req;
      e.rden     = (m_cur >= 0);
      e.mute     = !(m_cur >= 0 && m_pos > 0);
      e.busy     = (m_cur >= 0) || (m_gap > 0);
      e.done     = done;
      e.grant    = (m_cur >= 0) ? (4'(1) << m_cur) : 4'b0;
      e.chk_addr = (m_cur >= 0);
      e.addr     = (m_cur >= 0) ? 32'(START_A[m_cur] + m_pos) : 32'd0;
    end
    sb.push_back(e);
  end

  // Monitor: one expected record per clock edge, sampled 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty t=%0t got no expected record, required one", $time);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bus.rom_rden, bus.mute, bus.busy, bus.clip_done, bus.grant} !==
          {e.rden, e.mute, e.busy, e.done, e.grant}) begin
        errors++;
        $display("FAIL ctrl t=%0t rden/mute/busy/done/grant got %b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                 $time, bus.rom_rden, bus.mute, bus.busy, bus.clip_done, bus.grant,
                 e.rden, e.mute, e.busy, e.done, e.grant);
      end
      if (e.chk_addr) begin
        checks++;
        if (bus.rom_addr !== ADDR_W'(e.addr)) begin
          errors++;
          $display("FAIL rom_addr t=%0t got %0d required %0d", $time, bus.rom_addr, e.addr);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] r, input int n);
    bus.req = r;
    cyc(n);
    bus.req = '0;
  endtask

  // Wait until scheduler has been idle three cycles in a row.
  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 3; i++) begin
      cyc(1);
      quiet = bus.busy ? 0 : quiet + 1;
    end
    if (quiet < 3) begin
      checks++; errors++;
      $display("FAIL timeout_%s got busy still set, required idle", tag);
    end
  endtask

  task automatic wait_addr(input int a, input string tag);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc(1);
      hit = bus.rom_rden && (bus.rom_addr == ADDR_W'(a));
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL timeout_%s got no rom_addr %0d, required it", tag, a);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; bus.req = '0; bus.abort = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(10);

    pulse_req(4'b0010, 1);
    wait_idle("single");

    pulse_req(4'b1010, 1);
    wait_idle("contention");

    bus.req = 4'b0011;
    cyc(150);
    bus.req = '0;
    wait_idle("alternate");

    pulse_req(4'b0010, 1);
    wait_addr(50010, "abort");
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    wait_idle("abort");

    pulse_req(4'b0100, 1);
    wait_addr(100003, "enable_drop");
    pulse_req(4'b0001, 1);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    wait_idle("enable_drop");

    pulse_req(4'b1001, 1);
    wait_addr(5, "reset_mid");
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(10);

    pulse_req(4'b0100, 2);
    wait_idle("requeue");

    for (int i = 0; i < 3000; i++) begin
      bus.req   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      bus.abort = ($urandom_range(0, 59) == 0);
      enable    = ($urandom_range(0, 149) != 0);
      reset     = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    bus.req = '0; bus.abort = 1'b0; enable = 1'b1; reset = 1'b1;
    wait_idle("random");
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
